// File: rtl/stream_mux_arb.sv
// N_CH:1 packet-locked stream multiplexer with registered output stage.
// Channel chosen by SEL or by round-robin, held until the LAST beat.
module stream_mux_arb #(
  parameter int WIDTH    = 8,
  parameter int N_CH     = 4,
  parameter int ARB_MODE = 0,
  localparam int SEL_W   = $clog2(N_CH)
)(
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [N_CH*WIDTH-1:0] IN_DATA,
  input  logic [N_CH-1:0]       IN_VALID,
  input  logic [N_CH-1:0]       IN_LAST,
  output logic [N_CH-1:0]       IN_READY,
  input  logic [SEL_W-1:0]      SEL,
  output logic [WIDTH-1:0]      OUT_DATA,
  output logic                  OUT_VALID,
  output logic                  OUT_LAST,
  input  logic                  OUT_READY,
  output logic [SEL_W-1:0]      GRANT,
  output logic                  BUSY
);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t           state_q;
  state_t           state_d;
  logic [SEL_W-1:0] ptr_q;
  logic [SEL_W-1:0] cand;
  logic             found;
  logic             can_acc;
  logic             xfer;
  logic             last_g;
  logic [WIDTH-1:0] data_g;
  int               idx;

  assign can_acc = !OUT_VALID || OUT_READY;
  assign data_g  = IN_DATA[int'(GRANT)*WIDTH +: WIDTH];
  assign last_g  = IN_LAST[GRANT];
  assign xfer    = (state_q == LOCKED) && IN_VALID[GRANT] && can_acc;
  assign BUSY    = (state_q == LOCKED);

  // Candidate search: fixed select, or rotating scan starting after PTR
  always_comb begin
    cand  = '0;
    found = 1'b0;
    idx   = 0;
    if (ARB_MODE == 0) begin
      if (int'(SEL) < N_CH && IN_VALID[SEL]) begin
        found = 1'b1;
        cand  = SEL;
      end
    end else begin
      for (int k = 1; k <= N_CH; k++) begin
        idx = (int'(ptr_q) + k) % N_CH;
        if (!found && IN_VALID[idx]) begin
          found = 1'b1;
          cand  = SEL_W'(idx);
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:   if (found) state_d = LOCKED;
      LOCKED: if (xfer && last_g) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    IN_READY = '0;
    if (!RST && state_q == LOCKED)
      IN_READY[GRANT] = can_acc;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= IDLE;
      ptr_q     <= SEL_W'(N_CH - 1);
      GRANT     <= '0;
      OUT_VALID <= 1'b0;
      OUT_DATA  <= '0;
      OUT_LAST  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && found)
        GRANT <= cand;
      // A fresh beat overrides the pop so the stage never bubbles
      if (xfer) begin
        OUT_VALID <= 1'b1;
        OUT_DATA  <= data_g;
        OUT_LAST  <= last_g;
        if (last_g && ARB_MODE != 0)
          ptr_q <= GRANT;
      end else if (OUT_READY) begin
        OUT_VALID <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_stream_mux_arb.sv
// Directed bench for stream_mux_arb: one instance per arbitration mode,
// checked every cycle against a packet-level model plus literal expectations.
module tb_stream_mux_arb;

  logic        clk;
  logic        rst[2];
  logic [31:0] idata[2];
  logic [3:0]  ivalid[2];
  logic [3:0]  ilast[2];
  logic [3:0]  iready[2];
  logic [1:0]  sel[2];
  logic [7:0]  odata[2];
  logic        ovalid[2];
  logic        olast[2];
  logic        oready[2];
  logic [1:0]  grant[2];
  logic        busy[2];

  int vectors = 0;
  int miscompares = 0;

  bit       m_lock[2];
  int       m_grant[2];
  int       m_ptr[2];
  bit       m_ov[2];
  bit       m_ol[2];
  bit [7:0] m_od[2];

  stream_mux_arb #(.WIDTH(8), .N_CH(4), .ARB_MODE(0)) dut0 (
    .CLK(clk), .RST(rst[0]), .IN_DATA(idata[0]), .IN_VALID(ivalid[0]),
    .IN_LAST(ilast[0]), .IN_READY(iready[0]), .SEL(sel[0]),
    .OUT_DATA(odata[0]), .OUT_VALID(ovalid[0]), .OUT_LAST(olast[0]),
    .OUT_READY(oready[0]), .GRANT(grant[0]), .BUSY(busy[0])
  );

  stream_mux_arb #(.WIDTH(8), .N_CH(4), .ARB_MODE(1)) dut1 (
    .CLK(clk), .RST(rst[1]), .IN_DATA(idata[1]), .IN_VALID(ivalid[1]),
    .IN_LAST(ilast[1]), .IN_READY(iready[1]), .SEL(sel[1]),
    .OUT_DATA(odata[1]), .OUT_VALID(ovalid[1]), .OUT_LAST(olast[1]),
    .OUT_READY(oready[1]), .GRANT(grant[1]), .BUSY(busy[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Packet-level reference: lock, forward beats, release on LAST
  always @(posedge clk) begin
    for (int m = 0; m < 2; m++) begin
      bit acc;
      bit f;
      int c;
      if (rst[m]) begin
        m_lock[m] = 0; m_grant[m] = 0; m_ptr[m] = 3;
        m_ov[m] = 0; m_ol[m] = 0; m_od[m] = 0;
      end else begin
        acc = m_lock[m] && ivalid[m][m_grant[m]] && (!m_ov[m] || oready[m]);
        if (!m_lock[m]) begin
          f = 0; c = 0;
          if (m == 0) begin
            if (ivalid[m][sel[m]]) begin f = 1; c = int'(sel[m]); end
          end else begin
            for (int k = 1; k <= 4; k++)
              if (!f && ivalid[m][(m_ptr[m] + k) % 4]) begin
                f = 1; c = (m_ptr[m] + k) % 4;
              end
          end
          if (f) begin m_lock[m] = 1; m_grant[m] = c; end
        end
        if (acc) begin
          m_ov[m] = 1;
          m_od[m] = idata[m][m_grant[m]*8 +: 8];
          m_ol[m] = ilast[m][m_grant[m]];
          if (m_ol[m]) begin
            m_lock[m] = 0;
            if (m == 1) m_ptr[m] = m_grant[m];
          end
        end else if (oready[m]) begin
          m_ov[m] = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int m = 0; m < 2; m++) begin
      logic [3:0] er;
      er = 4'b0;
      if (!rst[m] && m_lock[m] && (!m_ov[m] || oready[m]))
        er[m_grant[m]] = 1'b1;
      chk($sformatf("m%0d out_valid", m), 32'(ovalid[m]), 32'(m_ov[m]));
      chk($sformatf("m%0d busy", m), 32'(busy[m]), 32'(m_lock[m]));
      chk($sformatf("m%0d grant", m), 32'(grant[m]), 32'(m_grant[m]));
      chk($sformatf("m%0d in_ready", m), 32'(iready[m]), 32'(er));
      if (m_ov[m]) begin
        chk($sformatf("m%0d out_data", m), 32'(odata[m]), 32'(m_od[m]));
        chk($sformatf("m%0d out_last", m), 32'(olast[m]), 32'(m_ol[m]));
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  initial begin
    logic [1:0] order[5];
    logic [7:0] beats[4];
    logic [7:0] got[4];
    logic [7:0] held;
    int j;
    int n;
    bit acc;
    order = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    beats = '{8'hC0, 8'hC1, 8'hC2, 8'hC3};
    held = 8'h0;
    for (int m = 0; m < 2; m++) begin
      rst[m] = 1; idata[m] = 0; ivalid[m] = 4'hF; ilast[m] = 0;
      sel[m] = 0; oready[m] = 1;
      m_lock[m] = 0; m_grant[m] = 0; m_ptr[m] = 3;
      m_ov[m] = 0; m_ol[m] = 0; m_od[m] = 0;
    end

    // reset with all channels valid
    tick; tick;
    for (int m = 0; m < 2; m++) begin
      chk("rst out_valid", 32'(ovalid[m]), 0);
      chk("rst in_ready", 32'(iready[m]), 0);
      chk("rst grant", 32'(grant[m]), 0);
      chk("rst busy", 32'(busy[m]), 0);
    end

    // fixed select: ch2 three-beat packet, SEL moves mid-packet
    ivalid[0] = 4'b0; rst[0] = 0; tick;
    sel[0] = 2; ivalid[0] = 4'b0100; idata[0] = 32'h00A1_0000;
    tick;
    chk("t2 grant", 32'(grant[0]), 2);
    chk("t2 ready", 32'(iready[0]), 32'h4);
    sel[0] = 0;
    tick;
    chk("t2 A1", 32'(odata[0]), 32'hA1);
    idata[0] = 32'h00A2_0000;
    tick;
    chk("t2 A2", 32'(odata[0]), 32'hA2);
    chk("t2 grant held", 32'(grant[0]), 2);
    idata[0] = 32'h00A3_0000; ilast[0] = 4'b0100;
    tick;
    chk("t2 A3", 32'(odata[0]), 32'hA3);
    chk("t2 A3 last", 32'(olast[0]), 1);
    chk("t2 busy low", 32'(busy[0]), 0);
    ivalid[0] = 0; ilast[0] = 0;
    tick;

    // selected channel idle while others valid
    sel[0] = 1; ivalid[0] = 4'b1101; ilast[0] = 4'hF;
    idata[0] = 32'h4433_2211;
    tick; tick;
    chk("t6 busy", 32'(busy[0]), 0);
    chk("t6 ready", 32'(iready[0]), 0);
    ivalid[0] = 4'hF;
    tick;
    chk("t6 grant", 32'(grant[0]), 1);
    chk("t6 busy", 32'(busy[0]), 1);
    tick;
    chk("t6 data", 32'(odata[0]), 32'h22);
    ivalid[0] = 0;
    tick;

    // round-robin with single-beat packets on every channel
    rst[1] = 0; ivalid[1] = 4'hF; ilast[1] = 4'hF;
    idata[1] = 32'h1312_1110;
    for (int t = 0; t < 10; t++) begin
      tick;
      if (t % 2 == 0) begin
        chk("t3 busy", 32'(busy[1]), 1);
        chk("t3 grant", 32'(grant[1]), 32'(order[t / 2]));
      end else begin
        chk("t3 gap", 32'(busy[1]), 0);
      end
    end
    ivalid[1] = 0; ilast[1] = 0;
    tick; tick;

    // four-beat ch2 packet with a three-cycle consumer stall
    j = 0; n = 0;
    got = '{8'h0, 8'h0, 8'h0, 8'h0};
    for (int c = 0; c < 20; c++) begin
      oready[1] = !(c >= 3 && c <= 5);
      ivalid[1] = (j < 4) ? 4'b0100 : 4'b0;
      idata[1] = (j < 4) ? 32'(beats[j]) << 16 : 32'h0;
      ilast[1] = (j == 3) ? 4'b0100 : 4'b0;
      #1;
      acc = ivalid[1][2] && iready[1][2];
      if (ovalid[1] && oready[1]) begin
        if (n < 4) got[n] = odata[1];
        n++;
      end
      if (c == 3) held = odata[1];
      if (c == 4 || c == 5) begin
        chk("t4 hold", 32'(odata[1]), 32'(held));
        chk("t4 stall ready", 32'(iready[1][2]), 0);
      end
      tick;
      if (acc) j++;
    end
    oready[1] = 1;
    chk("t4 count", n, 4);
    for (int b = 0; b < 4; b++)
      chk("t4 beat", 32'(got[b]), 32'(beats[b]));

    // reset in the middle of a ch3 packet
    j = 0;
    for (int c = 0; c < 10 && j < 2; c++) begin
      ivalid[1] = 4'b1000;
      idata[1] = {8'hD0 + 8'(j), 24'h0};
      ilast[1] = 0;
      #1;
      acc = iready[1][3];
      tick;
      if (acc) j++;
    end
    chk("t5 two beats", j, 2);
    chk("t5 busy before", 32'(busy[1]), 1);
    rst[1] = 1;
    tick;
    chk("t5 out_valid", 32'(ovalid[1]), 0);
    chk("t5 busy", 32'(busy[1]), 0);
    rst[1] = 0; ivalid[1] = 4'b1001; ilast[1] = 4'b1001;
    idata[1] = 32'hD300_00E0;
    tick;
    chk("t5 grant", 32'(grant[1]), 0);
    tick;
    chk("t5 data", 32'(odata[1]), 32'hE0);
    ivalid[1] = 0; ilast[1] = 0;
    tick; tick;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
